// File: rtl/clk_gate_pkg.sv
// Shared types and default constants for the per-channel clock-gating controller.
package clk_gate_pkg;

  // Channel lifecycle: running, counting idle cycles, clock stopped, restarting.
  typedef enum logic [1:0] {
    ST_ON    = 2'd0,
    ST_IDLE  = 2'd1,
    ST_GATED = 2'd2,
    ST_WAKE  = 2'd3
  } chan_state_t;

  localparam int unsigned DEF_NUM_CH      = 4;
  localparam int unsigned DEF_IDLE_CNT_W  = 8;
  localparam int unsigned DEF_WAKE_CYCLES = 2;
  localparam int unsigned DEF_STAT_W      = 16;

  // Wake latency is at most 15 cycles, so four bits always hold it.
  localparam int unsigned WAKE_CNT_W = 4;

endpackage

// File: rtl/clk_gate_chan.sv
// One gated clock channel: idle detection, gating FSM, wake delay,
// saturating gated-cycle counter and its clock-gate cell.
module clk_gate_chan
  import clk_gate_pkg::*;
#(
  parameter int unsigned IDLE_CNT_W  = DEF_IDLE_CNT_W,
  parameter int unsigned WAKE_CYCLES = DEF_WAKE_CYCLES,
  parameter int unsigned STAT_W      = DEF_STAT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  gate_en,
  input  logic [IDLE_CNT_W-1:0] idle_thresh,
  input  logic                  busy,
  input  logic                  force_on,
  input  logic                  wake_req,
  input  logic                  stat_clr,
  output logic                  clk_gated,
  output logic                  chan_ready,
  output logic                  chan_gated,
  output logic [STAT_W-1:0]     gated_cycles,
  output chan_state_t           state_o
);

  localparam logic [WAKE_CNT_W-1:0] WAKE_INIT = WAKE_CNT_W'(WAKE_CYCLES);

  chan_state_t             state;
  logic                    clk_en_q;
  logic                    ready_q;
  logic                    gated_q;
  logic [IDLE_CNT_W-1:0]   idle_cnt;
  logic [WAKE_CNT_W-1:0]   wake_cnt;
  logic [STAT_W-1:0]       stat_cnt;

  logic idle_abort;
  logic wake_cond;

  // Anything that wants the clock back; idle additionally aborts on threshold 0.
  assign wake_cond  = busy | wake_req | force_on | ~gate_en;
  assign idle_abort = wake_cond | (idle_thresh == '0);

  // Channel FSM; clock enable, ready and gated flags are registered with it
  // so the gate-cell enable never sees a combinational input path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_ON;
      clk_en_q <= 1'b1;
      ready_q  <= 1'b1;
      gated_q  <= 1'b0;
      idle_cnt <= '0;
      wake_cnt <= '0;
    end else begin
      case (state)
        ST_ON: begin
          if (!busy && !force_on && gate_en && (idle_thresh != '0)) begin
            state    <= ST_IDLE;
            idle_cnt <= IDLE_CNT_W'(1);
          end
        end
        ST_IDLE: begin
          if (idle_abort) begin
            state    <= ST_ON;
            idle_cnt <= '0;
          end else if (idle_cnt >= idle_thresh) begin
            // >= rather than == so a threshold lowered mid-count still gates.
            state    <= ST_GATED;
            clk_en_q <= 1'b0;
            ready_q  <= 1'b0;
            gated_q  <= 1'b1;
            idle_cnt <= '0;
          end else begin
            idle_cnt <= idle_cnt + IDLE_CNT_W'(1);
          end
        end
        ST_GATED: begin
          if (wake_cond) begin
            state    <= ST_WAKE;
            clk_en_q <= 1'b1;
            gated_q  <= 1'b0;
            wake_cnt <= WAKE_INIT;
          end
        end
        ST_WAKE: begin
          // Not abortable: inputs are ignored until the count expires.
          wake_cnt <= wake_cnt - WAKE_CNT_W'(1);
          if (wake_cnt == WAKE_CNT_W'(1)) begin
            state   <= ST_ON;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state    <= ST_ON;
          clk_en_q <= 1'b1;
          ready_q  <= 1'b1;
          gated_q  <= 1'b0;
        end
      endcase
    end
  end

  // Saturating count of edges spent gated; clear takes priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_cnt <= '0;
    end else if (stat_clr) begin
      stat_cnt <= '0;
    end else if ((state == ST_GATED) && (stat_cnt != '1)) begin
      stat_cnt <= stat_cnt + STAT_W'(1);
    end
  end

  clk_gater_ul u_gater (
    .clk  (clk),
    .en   (clk_en_q),
    .gclk (clk_gated)
  );

  assign chan_ready   = ready_q;
  assign chan_gated   = gated_q;
  assign gated_cycles = stat_cnt;
  assign state_o      = state;

endmodule

// File: rtl/clk_gater_ul.sv
// Glitch-free clock gate: enable is captured by a latch that is transparent
// only while the clock is low, so the gated clock can never be clipped.
module clk_gater_ul (
  input  logic clk,
  input  logic en,
  output logic gclk
);

  logic en_lat;

  // Open while clk is low; holds the enable stable through the high phase.
  always_latch begin
    if (!clk) en_lat <= en;
  end

  assign gclk = clk & en_lat;

endmodule

// File: rtl/clk_gate_ctrl_ul.sv
// Multi-channel clock-gating controller: NUM_CH independent channels sharing
// the global permission, idle threshold and stat-clear controls.
module clk_gate_ctrl_ul
  import clk_gate_pkg::*;
#(
  parameter int unsigned NUM_CH      = DEF_NUM_CH,
  parameter int unsigned IDLE_CNT_W  = DEF_IDLE_CNT_W,
  parameter int unsigned WAKE_CYCLES = DEF_WAKE_CYCLES,
  parameter int unsigned STAT_W      = DEF_STAT_W
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     gateEn_i,
  input  logic [IDLE_CNT_W-1:0]    idleThresh_i,
  input  logic [NUM_CH-1:0]        busy_i,
  input  logic [NUM_CH-1:0]        forceOn_i,
  input  logic [NUM_CH-1:0]        wakeReq_i,
  input  logic                     statClr_i,
  output logic [NUM_CH-1:0]        clkGated_o,
  output logic [NUM_CH-1:0]        chanReady_o,
  output logic [NUM_CH-1:0]        chanGated_o,
  output logic [NUM_CH*STAT_W-1:0] gatedCycles_o,
  // Debug view of every channel FSM, two bits per channel, channel 0 in LSBs.
  output logic [NUM_CH*2-1:0]      chanState_o
);

  // One fully independent channel per clock output.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    chan_state_t st;

    clk_gate_chan #(
      .IDLE_CNT_W  (IDLE_CNT_W),
      .WAKE_CYCLES (WAKE_CYCLES),
      .STAT_W      (STAT_W)
    ) u_chan (
      .clk          (clk_i),
      .rst          (reset_i),
      .gate_en      (gateEn_i),
      .idle_thresh  (idleThresh_i),
      .busy         (busy_i[g]),
      .force_on     (forceOn_i[g]),
      .wake_req     (wakeReq_i[g]),
      .stat_clr     (statClr_i),
      .clk_gated    (clkGated_o[g]),
      .chan_ready   (chanReady_o[g]),
      .chan_gated   (chanGated_o[g]),
      .gated_cycles (gatedCycles_o[g*STAT_W +: STAT_W]),
      .state_o      (st)
    );

    assign chanState_o[g*2 +: 2] = st;
  end

endmodule
